// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N-to-1 word multiplexer with valid/ready on every input channel
// and on the output. The output is a one-entry pipeline register. Selection is
// either a static external select (MODE=0) or round-robin arbitration (MODE=1).
//
// Optional feature macro: MUX_RR_PKT_LOCK_EN
//   When defined, adds in_last/out_last. A multi-beat packet locks the grant
//   onto its channel until the beat with in_last=1 is transferred.
module mux_rr_nx1 #(
  parameter int unsigned  WIDTH    = 8,
  parameter int unsigned  CHANNELS = 16,
  parameter int unsigned  MODE     = 1,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
`ifdef MUX_RR_PKT_LOCK_EN
  ,
  input  logic [CHANNELS-1:0]       in_last,
  output logic                      out_last
`endif
);

  // Highest legal channel index; the pointer wraps here, not at 2^SEL_W-1.
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [SEL_W-1:0] out_chan_q;
  logic [SEL_W-1:0] out_chan_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;

  logic             load;
  logic             xfer;
  logic [SEL_W-1:0] grant;
  logic             grant_active;
  logic [WIDTH-1:0] grant_word;
  logic             grant_last;

  // Round-robin scan results: first requester at or above ptr, and first overall.
  logic             rr_hi_found;
  logic [SEL_W-1:0] rr_hi_idx;
  logic             rr_lo_found;
  logic [SEL_W-1:0] rr_lo_idx;

`ifdef MUX_RR_PKT_LOCK_EN
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e      state_q;
  lock_state_e      state_d;
  logic [SEL_W-1:0] lock_chan_q;
  logic [SEL_W-1:0] lock_chan_d;
  logic             out_last_q;
  logic             out_last_d;
`endif

  // Output register can accept a new word when empty or being drained this cycle.
  assign load = !out_valid_q || out_ready;

  // Round-robin priority scan starting at ptr, wrapping to channel 0.
  always_comb begin
    rr_hi_found = 1'b0;
    rr_hi_idx   = '0;
    rr_lo_found = 1'b0;
    rr_lo_idx   = '0;
    for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        rr_lo_found = 1'b1;
        rr_lo_idx   = SEL_W'(i);
        if (SEL_W'(i) >= ptr_q) begin
          rr_hi_found = 1'b1;
          rr_hi_idx   = SEL_W'(i);
        end
      end
    end
  end

  // Grant selection: packet lock first, then static select or round-robin.
  always_comb begin
    grant        = '0;
    grant_active = 1'b0;
    if (MODE == 0) begin
      grant = sel;
      // An out-of-range select matches no channel and so grants nothing.
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (sel == SEL_W'(i)) begin
          grant_active = in_valid[i];
        end
      end
    end else begin
      grant        = rr_hi_found ? rr_hi_idx : rr_lo_idx;
      grant_active = rr_hi_found || rr_lo_found;
    end
`ifdef MUX_RR_PKT_LOCK_EN
    if (state_q == ST_LOCKED) begin
      grant        = lock_chan_q;
      grant_active = 1'b0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (lock_chan_q == SEL_W'(i)) begin
          grant_active = in_valid[i];
        end
      end
    end
`endif
  end

  // Word (and last flag) of the granted channel.
  always_comb begin
    grant_word = '0;
    grant_last = 1'b1;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (grant == SEL_W'(i)) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_RR_PKT_LOCK_EN
        grant_last = in_last[i];
`endif
      end
    end
  end

  // A transfer happens on the granted channel; reset blocks all handshakes.
  assign xfer = !rst && load && grant_active;

  // One-hot ready toward the granted channel only.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      in_ready[i] = xfer && (grant == SEL_W'(i));
    end
  end

  // Next value of output register and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
`ifdef MUX_RR_PKT_LOCK_EN
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_data_d  = grant_word;
      out_chan_d  = grant;
      out_valid_d = 1'b1;
`ifdef MUX_RR_PKT_LOCK_EN
      out_last_d  = grant_last;
`endif
      // Inside a locked packet the pointer advances only on the last beat.
      if (grant_last) begin
        ptr_d = (grant == LAST_CH) ? '0 : grant + SEL_W'(1);
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and pointer state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef MUX_RR_PKT_LOCK_EN
  // Packet-lock next state: lock on a non-last beat, release on the last beat.
  always_comb begin
    state_d     = state_q;
    lock_chan_d = lock_chan_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && !grant_last) begin
          state_d     = ST_LOCKED;
          lock_chan_d = grant;
        end
      end
      ST_LOCKED: begin
        if (xfer && grant_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Packet-lock state register and registered last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lock_chan_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_chan_q <= lock_chan_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_last = out_last_q;
`endif

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Testbench for mux_rr_nx1: a round-robin instance (16 channels) and a static
// select instance (12 channels), checked against a behavioural model whose
// expected words go through per-instance scoreboard queues.
module tb_mux_rr_nx1;

  localparam int unsigned W  = 8;
  localparam int unsigned CA = 16;
  localparam int unsigned CB = 12;

  typedef struct packed {
    logic [3:0] chan;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [15:0]   s_iv   [2];
  logic          s_ordy [2];
  logic [15:0]   s_last [2];
  logic [3:0]    s_sel;
  logic [W-1:0]  dat_a  [CA];
  logic [W-1:0]  dat_b  [CB];

  logic [CA*W-1:0] in_data_a;
  logic [CB*W-1:0] in_data_b;
  logic [CA-1:0]   in_ready_a;
  logic [CB-1:0]   in_ready_b;
  logic [W-1:0]    out_data_a;
  logic [W-1:0]    out_data_b;
  logic            out_valid_a;
  logic            out_valid_b;
  logic [3:0]      out_chan_a;
  logic [3:0]      out_chan_b;
  logic            out_last_a;
  logic            out_last_b;

  // Model state, index 0 = round-robin instance, 1 = static-select instance.
  int   m_ptr  [2];
  bit   m_vld  [2];
  bit   m_lock [2];
  int   m_lch  [2];
  bit   m_xfer [2];
  bit   m_load [2];
  int   m_g    [2];
  bit   m_glast[2];
  exp_t q0[$];
  exp_t q1[$];

  int n_checks;
  int n_err;

  always_comb begin
    for (int i = 0; i < int'(CA); i++) in_data_a[i*W +: W] = dat_a[i];
    for (int i = 0; i < int'(CB); i++) in_data_b[i*W +: W] = dat_b[i];
  end

  mux_rr_nx1 #(.WIDTH(W), .CHANNELS(CA), .MODE(1)) u_dut_rr (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data_a),
    .in_valid  (s_iv[0]),
    .in_ready  (in_ready_a),
    .sel       (4'd0),
    .out_data  (out_data_a),
    .out_valid (out_valid_a),
    .out_ready (s_ordy[0]),
    .out_chan  (out_chan_a)
`ifdef MUX_RR_PKT_LOCK_EN
    ,
    .in_last   (s_last[0]),
    .out_last  (out_last_a)
`endif
  );

  mux_rr_nx1 #(.WIDTH(W), .CHANNELS(CB), .MODE(0)) u_dut_st (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data_b),
    .in_valid  (s_iv[1][11:0]),
    .in_ready  (in_ready_b),
    .sel       (s_sel),
    .out_data  (out_data_b),
    .out_valid (out_valid_b),
    .out_ready (s_ordy[1]),
    .out_chan  (out_chan_b)
`ifdef MUX_RR_PKT_LOCK_EN
    ,
    .in_last   (s_last[1][11:0]),
    .out_last  (out_last_b)
`endif
  );

`ifndef MUX_RR_PKT_LOCK_EN
  assign out_last_a = 1'b0;
  assign out_last_b = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Model one instance for the current cycle: grant, ready, output drain.
  task automatic side(input int d, input logic [15:0] rdy, input logic ov,
                      input logic [7:0] od, input logic [3:0] oc, input logic ol);
    int          nch;
    bit          act;
    int          g;
    int          sz;
    logic [15:0] exp_rdy;
    exp_t        e;
    string       p;
    p   = (d == 0) ? "rr" : "st";
    nch = (d == 0) ? int'(CA) : int'(CB);
    act = 1'b0;
    g   = 0;
    if (m_lock[d]) begin
      g   = m_lch[d];
      act = s_iv[d][g];
    end else if (d == 1) begin
      g   = int'(s_sel);
      act = (g < nch) && s_iv[1][g];
    end else begin
      for (int k = nch - 1; k >= 0; k--) begin
        int idx;
        idx = (m_ptr[d] + k) % nch;
        if (s_iv[d][idx]) begin
          act = 1'b1;
          g   = idx;
        end
      end
    end
    m_load[d]  = !m_vld[d] || s_ordy[d];
    m_xfer[d]  = !rst && m_load[d] && act;
    m_g[d]     = g;
    m_glast[d] = s_last[d][g];
    exp_rdy    = m_xfer[d] ? (16'd1 << g) : 16'd0;
    check_eq({p, "_in_ready"}, 32'(rdy), 32'(exp_rdy));
    check_eq({p, "_out_valid"}, 32'(ov), 32'(m_vld[d]));
    if (!rst && m_vld[d] && s_ordy[d]) begin
      sz = (d == 0) ? q0.size() : q1.size();
      check_eq({p, "_sb_nonempty"}, 32'(sz != 0), 32'(1));
      if (sz != 0) begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check_eq({p, "_out_data"}, 32'(od), 32'(e.data));
        check_eq({p, "_out_chan"}, 32'(oc), 32'(e.chan));
`ifdef MUX_RR_PKT_LOCK_EN
        check_eq({p, "_out_last"}, 32'(ol), 32'(e.last));
`endif
      end
    end
    if (m_xfer[d]) begin
      e.chan = 4'(g);
      e.last = s_last[d][g];
      if (d == 0) begin
        e.data = dat_a[g];
        q0.push_back(e);
      end else begin
        e.data = dat_b[g];
        q1.push_back(e);
      end
    end
  endtask

  // One clock: check both instances, take the edge, advance the model.
  task automatic cycle();
    bit upd_ptr;
    int nch;
    #2;
    side(0, 16'(in_ready_a), out_valid_a, out_data_a, out_chan_a, out_last_a);
    side(1, 16'(in_ready_b), out_valid_b, out_data_b, out_chan_b, out_last_b);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      nch = (d == 0) ? int'(CA) : int'(CB);
      if (rst) begin
        m_vld[d]  = 1'b0;
        m_ptr[d]  = 0;
        m_lock[d] = 1'b0;
        m_lch[d]  = 0;
      end else if (m_xfer[d]) begin
        m_vld[d] = 1'b1;
        upd_ptr  = 1'b1;
`ifdef MUX_RR_PKT_LOCK_EN
        if (!m_lock[d] && !m_glast[d]) begin
          m_lock[d] = 1'b1;
          m_lch[d]  = m_g[d];
        end else if (m_lock[d] && m_glast[d]) begin
          m_lock[d] = 1'b0;
        end
        upd_ptr = m_glast[d];
`endif
        if (upd_ptr) m_ptr[d] = (m_g[d] == nch - 1) ? 0 : m_g[d] + 1;
      end else if (m_load[d]) begin
        m_vld[d] = 1'b0;
      end
    end
    if (rst) begin
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    s_sel    = 4'd0;
    for (int d = 0; d < 2; d++) begin
      s_iv[d]   = 16'h0;
      s_ordy[d] = 1'b1;
      s_last[d] = 16'hFFFF;
      m_ptr[d]  = 0;
      m_vld[d]  = 1'b0;
      m_lock[d] = 1'b0;
      m_lch[d]  = 0;
      m_xfer[d] = 1'b0;
      m_load[d] = 1'b0;
      m_g[d]    = 0;
      m_glast[d] = 1'b1;
    end
    for (int i = 0; i < int'(CA); i++) dat_a[i] = 8'h0;
    for (int i = 0; i < int'(CB); i++) dat_b[i] = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check_eq("rst_rr_valid", 32'(out_valid_a), 32'(0));
    check_eq("rst_rr_data",  32'(out_data_a),  32'(0));
    check_eq("rst_rr_chan",  32'(out_chan_a),  32'(0));
    check_eq("rst_st_valid", 32'(out_valid_b), 32'(0));
    check_eq("rst_st_data",  32'(out_data_b),  32'(0));
    check_eq("rst_st_chan",  32'(out_chan_b),  32'(0));
`ifdef MUX_RR_PKT_LOCK_EN
    check_eq("rst_rr_last",  32'(out_last_a),  32'(0));
`endif

    // All 16 channels valid: grant rotates 0..15,0 with no idle cycles
    for (int i = 0; i < int'(CA); i++) dat_a[i] = 8'(8'h10 + i);
    s_iv[0] = 16'hFFFF;
    for (int k = 0; k <= 17; k++) begin
      if (k >= 1) begin
        check_eq("rot_valid", 32'(out_valid_a), 32'(1));
        check_eq("rot_chan",  32'(out_chan_a),  32'((k - 1) % 16));
        check_eq("rot_data",  32'(out_data_a),  32'(8'h10 + (k - 1) % 16));
      end
      if (k < 17) cycle();
    end
    s_iv[0] = 16'h0;
    cycle();

    // Only ch3 and ch9 requesting from ptr=0: alternate 3,9 with ptr 4,10
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    s_iv[0] = 16'h0208;
    for (int k = 0; k <= 4; k++) begin
      if (k >= 1) begin
        check_eq("alt_chan", 32'(out_chan_a), 32'((k % 2 == 1) ? 3 : 9));
        check_eq("alt_ptr",  32'(u_dut_rr.ptr_q), 32'((k % 2 == 1) ? 4 : 10));
      end
      if (k < 4) cycle();
    end
    s_iv[0] = 16'h0;
    cycle();

    // Backpressure: held word stays stable, then drain and reload in one cycle
    dat_a[2] = 8'hA5;
    s_iv[0]  = 16'h0004;
    cycle();
    dat_a[2]  = 8'h5B;
    dat_a[5]  = 8'h77;
    s_iv[0]   = 16'h0024;
    s_ordy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("bp_valid", 32'(out_valid_a), 32'(1));
      check_eq("bp_data",  32'(out_data_a),  32'(8'hA5));
    end
    s_ordy[0] = 1'b1;
    cycle();
    check_eq("bp_next_chan", 32'(out_chan_a), 32'(5));
    check_eq("bp_next_data", 32'(out_data_a), 32'(8'h77));
    s_iv[0] = 16'h0;
    cycle();

    // Static select: sel=7 passes ch7, sel=13 grants nothing
    s_sel    = 4'd7;
    s_iv[1]  = 16'h0080;
    dat_b[7] = 8'h3C;
    cycle();
    check_eq("st_data",  32'(out_data_b),  32'(8'h3C));
    check_eq("st_chan",  32'(out_chan_b),  32'(7));
    check_eq("st_valid", 32'(out_valid_b), 32'(1));
    s_sel   = 4'd13;
    s_iv[1] = 16'hFFFF;
    cycle();
    check_eq("st_oor_valid", 32'(out_valid_b), 32'(0));

    // Select change while the output is held affects only the next grant
    s_sel    = 4'd7;
    s_iv[1]  = 16'h0090;
    dat_b[4] = 8'h44;
    cycle();
    s_ordy[1] = 1'b0;
    s_sel     = 4'd4;
    repeat (2) cycle();
    check_eq("st_hold_chan", 32'(out_chan_b), 32'(7));
    check_eq("st_hold_data", 32'(out_data_b), 32'(8'h3C));
    s_ordy[1] = 1'b1;
    cycle();
    check_eq("st_new_chan", 32'(out_chan_b), 32'(4));
    check_eq("st_new_data", 32'(out_data_b), 32'(8'h44));
    s_iv[1] = 16'h0;
    cycle();

    // Reset while a word is held and a transfer is pending
    dat_a[6] = 8'h66;
    s_iv[0]  = 16'h0040;
    cycle();
    s_ordy[0] = 1'b0;
    s_iv[0]   = 16'hFFFF;
    rst       = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("mrst_valid", 32'(out_valid_a), 32'(0));
    check_eq("mrst_data",  32'(out_data_a),  32'(0));
    check_eq("mrst_chan",  32'(out_chan_a),  32'(0));
    check_eq("mrst_ptr",   32'(u_dut_rr.ptr_q), 32'(0));
    s_ordy[0] = 1'b1;
    cycle();
    check_eq("mrst_first_chan", 32'(out_chan_a), 32'(0));
    s_iv[0] = 16'h0;
    cycle();

`ifdef MUX_RR_PKT_LOCK_EN
    // Packet lock: ch1 sends 3 beats while ch0 waits
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    dat_a[0] = 8'hC0;
    s_iv[0]  = 16'h0001;
    cycle();
    s_iv[0] = 16'h0003;
    for (int b = 0; b < 3; b++) begin
      s_last[0][1] = (b == 2);
      dat_a[1]     = 8'(8'hB0 + b);
      cycle();
      check_eq("lock_chan", 32'(out_chan_a), 32'(1));
      check_eq("lock_last", 32'(out_last_a), 32'(b == 2));
    end
    s_last[0] = 16'hFFFF;
    cycle();
    check_eq("unlock_chan", 32'(out_chan_a), 32'(0));
    s_iv[0] = 16'h0;
    cycle();
`endif

    // Random traffic on both instances
    for (int n = 0; n < 400; n++) begin
      s_iv[0]   = 16'($urandom) & 16'($urandom);
      s_iv[1]   = 16'($urandom) | 16'($urandom);
      s_ordy[0] = ($urandom_range(0, 3) != 0);
      s_ordy[1] = ($urandom_range(0, 3) != 0);
      s_sel     = 4'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 63) == 0);
`ifdef MUX_RR_PKT_LOCK_EN
      s_last[0] = 16'($urandom) | 16'($urandom);
      s_last[1] = 16'($urandom) | 16'($urandom);
`endif
      for (int i = 0; i < int'(CA); i++) dat_a[i] = 8'($urandom);
      for (int i = 0; i < int'(CB); i++) dat_b[i] = 8'($urandom);
      cycle();
    end

    // Drain everything still held
    rst       = 1'b0;
    s_iv[0]   = 16'h0;
    s_iv[1]   = 16'h0;
    s_ordy[0] = 1'b1;
    s_ordy[1] = 1'b1;
    repeat (3) cycle();
    check_eq("rr_sb_left", 32'(q0.size()), 32'(0));
    check_eq("st_sb_left", 32'(q1.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
